// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, synchronized row sampling, per-scan key
// detection, press/release debounce and a PicoBlaze-readable key latch.
`timescale 1ns/1ps

module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       pb_reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_overrun,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_MAX) return CNT_MAX;
    return v + CNT_ONE;
  endfunction

  // Index is {row, column}.
  function automatic logic [7:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [7:0] k;
    k = 8'h00;
    case ({r, c})
      4'h0: k = 8'h01;
      4'h1: k = 8'h02;
      4'h2: k = 8'h03;
      4'h3: k = 8'h0A;
      4'h4: k = 8'h04;
      4'h5: k = 8'h05;
      4'h6: k = 8'h06;
      4'h7: k = 8'h0B;
      4'h8: k = 8'h07;
      4'h9: k = 8'h08;
      4'hA: k = 8'h09;
      4'hB: k = 8'h0C;
      4'hC: k = 8'h00;
      4'hD: k = 8'h0F;
      4'hE: k = 8'h0E;
      4'hF: k = 8'h0D;
    endcase
    return k;
  endfunction

  logic [3:0]       row_p0, row_p1;
  logic [DIV_W-1:0] dwell_cnt;
  logic [1:0]       col_idx;
  logic             dwell_last, scan_done;
  logic             col_hit;
  logic [1:0]       hit_row;
  logic [7:0]       sample_code;
  logic             acc_hit;
  logic [7:0]       acc_code;
  logic             scan_hit;
  logic [7:0]       scan_code;
  state_t           state_q, state_n;
  logic [7:0]       cand_q, cand_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             publish;

  // Stage p0/p1: row synchronizer (idle-high = no key)
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  assign dwell_last = (dwell_cnt >= DWELL_LAST);
  assign scan_done  = dwell_last && (col_idx == 2'd3);

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
    end else if (dwell_last) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    col          = 4'hF;
    col[col_idx] = 1'b0;
  end

  always_comb begin
    col_hit = ~&row_p1;
    if (!row_p1[0])      hit_row = 2'd0;
    else if (!row_p1[1]) hit_row = 2'd1;
    else if (!row_p1[2]) hit_row = 2'd2;
    else                 hit_row = 2'd3;
    sample_code = key_map(col_idx, hit_row);
  end

  // Columns are visited in ascending order, so the first hit latched wins.
  assign scan_hit  = acc_hit | (dwell_last & col_hit);
  assign scan_code = acc_hit ? acc_code : sample_code;

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      acc_hit  <= 1'b0;
      acc_code <= 8'h00;
    end else if (scan_done) begin
      acc_hit  <= 1'b0;
      acc_code <= 8'h00;
    end else if (dwell_last && col_hit && !acc_hit) begin
      acc_hit  <= 1'b1;
      acc_code <= sample_code;
    end
  end

  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      state_q <= IDLE;
      cand_q  <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cand_q  <= cand_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cand_n  = cand_q;
    cnt_n   = cnt_q;
    publish = 1'b0;
    cnt_inc = sat_inc(cnt_q);
    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_hit) begin
            state_n = PRESS_DEB;
            cand_n  = scan_code;
            cnt_n   = CNT_ONE;
          end
        end
        PRESS_DEB: begin
          if (!scan_hit) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (scan_code == cand_q) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              publish = 1'b1;
              state_n = HELD;
              cnt_n   = '0;
            end
          end else begin
            cand_n = scan_code;
            cnt_n  = CNT_ONE;
          end
        end
        HELD: begin
          if (!scan_hit) begin
            state_n = REL_DEB;
            cnt_n   = CNT_ONE;
          end
        end
        REL_DEB: begin
          if (scan_hit) begin
            state_n = HELD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              state_n = IDLE;
              cnt_n   = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A read acknowledge coinciding with a publish is absorbed by the new code.
  always_ff @(posedge clk or posedge pb_reset) begin
    if (pb_reset) begin
      key_code    <= 8'h00;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else if (publish) begin
      key_code  <= cand_q;
      key_valid <= 1'b1;
      if (key_valid && !key_ack) key_overrun <= 1'b1;
    end else if (key_ack && key_valid) begin
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end
  end

  assign key_down = (state_q == HELD) || (state_q == REL_DEB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad electrical model, scan-level vector table,
// reset-mid-debounce sequence and random key/ack traffic against a run-length model.
`timescale 1ns/1ps

module tb_keypad_scanner;

  localparam int SD       = 4;
  localparam int DB       = 2;
  localparam int SCAN_CYC = 4 * SD;

  logic       clk = 1'b0;
  logic       pb_reset;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_ack;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_overrun;
  logic       key_down;

  logic [15:0] pressed;  // bit index = column*4 + row

  int errors = 0;
  int checks = 0;
  int prints = 0;

  // Key codes in the order rows 0..3, columns 0..3 within each row.
  logic [7:0] code_tab [16] = '{8'h01, 8'h02, 8'h03, 8'h0A,
                                8'h04, 8'h05, 8'h06, 8'h0B,
                                8'h07, 8'h08, 8'h09, 8'h0C,
                                8'h00, 8'h0F, 8'h0E, 8'h0D};

  int         cyc;
  logic       m_down;
  int         run_code, run_len, none_len;
  logic [7:0] m_code;
  logic       m_valid, m_ov;

  typedef struct {
    logic [15:0] keys;
    int          ack;   // 0 none, 1 ack in the scan_done cycle, 2 ack mid-scan
    logic [7:0]  code;
    logic        valid;
    logic        ov;
    logic        down;
  } vec_t;

  vec_t vt[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk        (clk),
    .pb_reset   (pb_reset),
    .row        (row),
    .col        (col),
    .key_ack    (key_ack),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_overrun(key_overrun),
    .key_down   (key_down)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its driven-low column onto its row.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (pressed[c*4 + r]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
    end
  endtask

  function automatic int scan_result(input logic [15:0] keys);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r]) return int'(code_tab[r*4 + c]);
    return -1;
  endfunction

  task automatic model_reset();
    cyc      = 0;
    m_down   = 1'b0;
    run_code = -1;
    run_len  = 0;
    none_len = 0;
    m_code   = 8'h00;
    m_valid  = 1'b0;
    m_ov     = 1'b0;
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = 4'hF;
    ec[(cyc / SD) % 4] = 1'b0;
    check("col", 32'(col), 32'(ec));
    check("key_code", 32'(key_code), 32'(m_code));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_overrun", 32'(key_overrun), 32'(m_ov));
    check("key_down", 32'(key_down), 32'(m_down));
  endtask

  // One clock: predict the effect of the coming edge, take it, compare.
  task automatic tick(input logic ack);
    logic pub;
    int   res;
    pub     = 1'b0;
    key_ack = ack;
    if (cyc % SCAN_CYC == SCAN_CYC - 1) begin
      res = scan_result(pressed);
      if (!m_down) begin
        if (res < 0) run_len = 0;
        else begin
          if (run_len > 0 && res == run_code) run_len++;
          else begin
            run_code = res;
            run_len  = 1;
          end
          if (run_len >= DB) begin
            pub      = 1'b1;
            m_down   = 1'b1;
            none_len = 0;
            run_len  = 0;
          end
        end
      end else begin
        if (res < 0) begin
          none_len++;
          if (none_len >= DB) m_down = 1'b0;
        end else none_len = 0;
      end
    end
    if (pub) begin
      if (m_valid && !ack) m_ov = 1'b1;
      m_code  = 8'(run_code);
      m_valid = 1'b1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    key_ack = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    pb_reset = 1'b1;
    key_ack  = 1'b0;
    #1;
    check("rst_col", 32'(col), 32'(4'b1110));
    check("rst_key_code", 32'(key_code), 32'h00);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_overrun", 32'(key_overrun), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    @(negedge clk);
    @(negedge clk);
    pb_reset = 1'b0;
    model_reset();
    check_outputs();
  endtask

  task automatic run_scan(input logic [15:0] keys, input int ackmode);
    pressed = keys;
    for (int i = 0; i < SCAN_CYC; i++)
      tick((ackmode == 1 && cyc % SCAN_CYC == SCAN_CYC - 1) ||
           (ackmode == 2 && cyc % SCAN_CYC == SCAN_CYC / 2));
  endtask

  initial begin
    logic [15:0] keys, prev;
    int          sel;

    // Single keys: (1,1)=0020 (0,3)=0008 (0,0)=0001 (2,3)=0800 (2,2)=0400 (3,3)=8000 (3,1)=2000
    vt.push_back(vec_t'{16'h0020, 0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0020, 0, 8'h05, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0020, 0, 8'h05, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h05, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h05, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0008, 0, 8'h05, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0000, 0, 8'h05, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0008, 0, 8'h05, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0008, 0, 8'h00, 1'b1, 1'b1, 1'b1});
    vt.push_back(vec_t'{16'h0008, 2, 8'h00, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h00, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0001, 0, 8'h00, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0001, 0, 8'h01, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h01, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h01, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0800, 0, 8'h01, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0800, 0, 8'h0E, 1'b1, 1'b1, 1'b1});
    vt.push_back(vec_t'{16'h0000, 2, 8'h0E, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h0E, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h1040, 0, 8'h0E, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h1040, 0, 8'h08, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h1000, 0, 8'h08, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h1000, 0, 8'h08, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h08, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h08, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0400, 0, 8'h08, 1'b1, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h0400, 1, 8'h09, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0400, 2, 8'h09, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0400, 2, 8'h09, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h09, 1'b0, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h09, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h8000, 0, 8'h09, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h2000, 0, 8'h09, 1'b0, 1'b0, 1'b0});
    vt.push_back(vec_t'{16'h2000, 0, 8'h0B, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h0B, 1'b1, 1'b0, 1'b1});
    vt.push_back(vec_t'{16'h0000, 0, 8'h0B, 1'b1, 1'b0, 1'b0});

    pressed  = 16'h0000;
    key_ack  = 1'b0;
    pb_reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset();

    foreach (vt[i]) begin
      run_scan(vt[i].keys, vt[i].ack);
      check($sformatf("vec%0d_code", i), 32'(key_code), 32'(vt[i].code));
      check($sformatf("vec%0d_valid", i), 32'(key_valid), 32'(vt[i].valid));
      check($sformatf("vec%0d_overrun", i), 32'(key_overrun), 32'(vt[i].ov));
      check($sformatf("vec%0d_down", i), 32'(key_down), 32'(vt[i].down));
    end

    // Reset in the middle of a press debounce discards the first hit.
    do_reset();
    run_scan(16'h0020, 0);
    check("pre_rst_valid", 32'(key_valid), 32'h0);
    for (int i = 0; i < 5; i++) tick(1'b0);
    do_reset();
    run_scan(16'h0020, 0);
    check("post_rst_scan1_valid", 32'(key_valid), 32'h0);
    check("post_rst_scan1_down", 32'(key_down), 32'h0);
    run_scan(16'h0020, 0);
    check("post_rst_scan2_valid", 32'(key_valid), 32'h1);
    check("post_rst_scan2_code", 32'(key_code), 32'h05);

    // Random keys per scan, random read acknowledges per cycle.
    do_reset();
    prev = 16'h0000;
    for (int s = 0; s < 60; s++) begin
      sel = int'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0) keys = prev;
      else if (sel < 4) keys = 16'h0000;
      else if (sel < 9) keys = 16'h0001 << $urandom_range(0, 15);
      else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      prev    = keys;
      pressed = keys;
      for (int i = 0; i < SCAN_CYC; i++) tick($urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, giving clk cycles each column is driven (10 us at 100 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4, giving the consecutive full scans needed to accept a press or a release.
REQ-003 The block SHALL have port clk, input, 1 bit: 100 MHz system clock.
REQ-004 The block SHALL have port pb_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, active-low, asynchronous to clk.
REQ-006 The block SHALL have port col, output, 4 bits: keypad column drive, one-hot-low.
REQ-007 The block SHALL have port key_ack, input, 1 bit: single-cycle pulse from the PicoBlaze port-06 read decode.
REQ-008 The block SHALL have port key_code, output, 8 bits: last accepted key code for PicoBlaze input port 06.
REQ-009 The block SHALL have port key_valid, output, 1 bit: an unread key_code is pending.
REQ-010 The block SHALL have port key_overrun, output, 1 bit: a key was accepted while key_valid was already set.
REQ-011 The block SHALL have port key_down, output, 1 bit: debounced key-held status.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer before any use.
REQ-013 col SHALL step 1110 -> 1101 -> 1011 -> 0111 -> 1110; each value SHALL be held exactly SCAN_DIV cycles, and one full scan SHALL take 4*SCAN_DIV cycles.
REQ-014 Synchronized row SHALL be sampled only in the last cycle of each column dwell.
REQ-015 Key codes SHALL map (column,row) as follows: (0,0)=01, (1,0)=02, (2,0)=03, (3,0)=0A, (0,1)=04, (1,1)=05, (2,1)=06, (3,1)=0B, (0,2)=07, (1,2)=08, (2,2)=09, (3,2)=0C, (0,3)=00, (1,3)=0F, (2,3)=0E, (3,3)=0D.
REQ-016 Within a scan, with multiple keys pressed, the lowest column SHALL win, then the lowest row.
REQ-017 At the end of column-3 dwell, a one-cycle scan_done SHALL register scan_hit and scan_code, then clear the per-scan accumulator.
REQ-018 The FSM SHALL have states IDLE, PRESS_DEB, HELD and REL_DEB, and SHALL act only on scan_done.
REQ-019 In IDLE, a hit SHALL go to PRESS_DEB with cand=scan_code and cnt=1; no hit SHALL stay in IDLE.
REQ-020 In PRESS_DEB, a hit with the same code SHALL increment cnt; at cnt==DEBOUNCE_SCANS it SHALL publish cand and go to HELD.
REQ-021 In PRESS_DEB, a hit with a different code SHALL set cand=new code and cnt=1; no hit SHALL go to IDLE.
REQ-022 In HELD, no hit SHALL go to REL_DEB with cnt=1; any hit, including a changed key, SHALL stay in HELD.
REQ-023 In REL_DEB, no hit SHALL increment cnt, and cnt==DEBOUNCE_SCANS SHALL go to IDLE; a hit SHALL return to HELD with no republish.
REQ-024 key_down SHALL be 1 exactly in HELD and REL_DEB.
REQ-025 On publish, key_code and key_valid SHALL update the cycle after scan_done.
REQ-026 If key_valid=1 and key_ack=0 in the publish cycle, key_overrun SHALL be set to 1.
REQ-027 key_ack with no publish in the same cycle SHALL clear key_valid and key_overrun on the next edge.
REQ-028 Simultaneous key_ack and publish SHALL leave key_valid=1 with the new code and overrun unchanged.
REQ-029 key_ack while key_valid=0 SHALL have no effect; key_code SHALL hold its value until the next publish.
REQ-030 The dwell counter and the debounce counter SHALL saturate and never wrap.

Reset
REQ-031 pb_reset SHALL force col=1110, key_code=00, key_valid=0, key_overrun=0, key_down=0, FSM=IDLE, all counters and synchronizer flops to 0 (synchronizer flops to 1 = no press).
REQ-032 Reset asserted mid-debounce or mid-scan SHALL discard all progress, and scanning SHALL restart at column 0 on the first edge after release.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2; scan = 16 cycles)
REQ-033 Hold key (1,1) steady from reset release -> key_valid=1, key_code=05, key_down=1 after the 2nd scan_done plus 1 cycle; col sequence and dwell checked every cycle.
REQ-034 Key (0,3) present one scan, absent the next, present the next -> no publish until 2 consecutive hits; then key_code=00, key_valid=1.
REQ-035 Publish 01 without ack, release 2 scans, press (2,3) -> key_code=0E, key_overrun=1; key_ack pulse -> key_valid=0, key_overrun=0 next cycle.
REQ-036 Keys (3,0) and (1,2) pressed together -> key_code=08 (column 1 wins); drop (1,2) while holding (3,0) -> no new publish.
REQ-037 key_ack coincident with publish cycle -> key_valid stays 1, new code loaded, key_overrun=0.
REQ-038 pb_reset pulsed during PRESS_DEB with cnt=1 -> all outputs at reset values; after release, 2 full scans are needed again before publish.
